fht_ctrl: RTL and testbench

- Sequencer for one radix-2 Fast Hartley Transform butterfly unit (3-input data, sin/cos twiddle, 2-cycle pipeline).
- Steps through all N_LOG2 stages and issues one butterfly per clock: three read addresses, a twiddle-ROM index and a read strobe.
- Returns write-back addresses and strobes delayed to line up with the butterfly outputs.
- Uses ping-pong data banks, so reads and writes in the same stage never collide.

---
 rtl/fht_ctrl.sv | 157 +++++++++++++++
 tb/tb_fht_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fht_ctrl.sv
// Sequencer for a radix-2 FHT butterfly: walks all stages, issues one butterfly per clock
// over ping-pong banks and returns write-back addresses aligned with the butterfly outputs.
module fht_ctrl #(
  parameter int unsigned N_LOG2  = 8,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned BUT_LAT = 2
) (
  input  logic                       iCLK,
  input  logic                       iRESET,
  input  logic                       iSTART,
  output logic                       oBUSY,
  output logic                       oDONE,
  output logic [$clog2(N_LOG2)-1:0]  oSTAGE,
  output logic                       oRD_EN,
  output logic                       oRD_BANK,
  output logic [N_LOG2-1:0]          oRD_ADDR_0,
  output logic [N_LOG2-1:0]          oRD_ADDR_1,
  output logic [N_LOG2-1:0]          oRD_ADDR_2,
  output logic [N_LOG2-2:0]          oTW_ADDR,
  output logic                       oWR_EN,
  output logic                       oWR_BANK,
  output logic [N_LOG2-1:0]          oWR_ADDR_0,
  output logic [N_LOG2-1:0]          oWR_ADDR_1
);

  localparam int unsigned D  = RD_LAT + BUT_LAT;
  localparam int unsigned SW = $clog2(N_LOG2);
  localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned PW = 2 + 2 * N_LOG2;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q;
  logic [SW-1:0]     s_q;
  logic [N_LOG2-2:0] j_q;
  logic [CW-1:0]     cnt_q;

  // Stage/index of the butterfly that would be issued at the coming edge.
  logic [SW-1:0]     iss_s;
  logic [N_LOG2-2:0] iss_j;
  logic [N_LOG2-1:0] iss_jw, h_w, k_w, base_w;
  logic [N_LOG2-1:0] iss_a0, iss_a1, iss_a2;
  logic [N_LOG2-2:0] iss_tw;

  always_comb begin
    iss_s = s_q;
    iss_j = '0;
    unique case (state_q)
      StIdle:  iss_s = '0;
      StRun:   iss_j = j_q + (N_LOG2-1)'(1);
      StDrain: iss_s = s_q + SW'(1);
      default: ;
    endcase
    iss_jw = {1'b0, iss_j};
    h_w    = N_LOG2'(1) << iss_s;
    k_w    = iss_jw & (h_w - N_LOG2'(1));
    // Block base is j with the low s bits cleared, doubled.
    base_w = (iss_jw & ~(h_w - N_LOG2'(1))) << 1;
    iss_a0 = base_w + k_w;
    iss_a1 = base_w + h_w + k_w;
    iss_a2 = base_w + h_w + ((h_w - k_w) & (h_w - N_LOG2'(1)));
    iss_tw = (N_LOG2-1)'(k_w << (SW'(N_LOG2 - 1) - iss_s));
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q    <= StIdle;
      s_q        <= '0;
      j_q        <= '0;
      cnt_q      <= '0;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
      oRD_EN     <= 1'b0;
      oRD_BANK   <= 1'b0;
      oRD_ADDR_0 <= '0;
      oRD_ADDR_1 <= '0;
      oRD_ADDR_2 <= '0;
      oTW_ADDR   <= '0;
    end else begin
      oDONE  <= 1'b0;
      oRD_EN <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iSTART) begin
            state_q    <= StRun;
            s_q        <= '0;
            j_q        <= '0;
            oBUSY      <= 1'b1;
            oRD_EN     <= 1'b1;
            oRD_BANK   <= iss_s[0];
            oRD_ADDR_0 <= iss_a0;
            oRD_ADDR_1 <= iss_a1;
            oRD_ADDR_2 <= iss_a2;
            oTW_ADDR   <= iss_tw;
          end
        end
        StRun: begin
          if (&j_q) begin
            state_q <= StDrain;
            cnt_q   <= '0;
          end else begin
            j_q        <= iss_j;
            oRD_EN     <= 1'b1;
            oRD_BANK   <= iss_s[0];
            oRD_ADDR_0 <= iss_a0;
            oRD_ADDR_1 <= iss_a1;
            oRD_ADDR_2 <= iss_a2;
            oTW_ADDR   <= iss_tw;
          end
        end
        StDrain: begin
          if (cnt_q == CW'(D - 1)) begin
            if (s_q == SW'(N_LOG2 - 1)) begin
              state_q <= StDone;
              oBUSY   <= 1'b0;
              oDONE   <= 1'b1;
            end else begin
              state_q    <= StRun;
              s_q        <= iss_s;
              j_q        <= '0;
              oRD_EN     <= 1'b1;
              oRD_BANK   <= iss_s[0];
              oRD_ADDR_0 <= iss_a0;
              oRD_ADDR_1 <= iss_a1;
              oRD_ADDR_2 <= iss_a2;
              oTW_ADDR   <= iss_tw;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          s_q     <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oSTAGE = s_q;

  // Write-back delay line: each issued butterfly reappears D cycles later.
  logic [PW-1:0] wr_pipe_q [D];

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int unsigned i = 0; i < D; i++) wr_pipe_q[i] <= '0;
    end else begin
      wr_pipe_q[0] <= {oRD_EN, ~oRD_BANK, oRD_ADDR_0, oRD_ADDR_1};
      for (int unsigned i = 1; i < D; i++) wr_pipe_q[i] <= wr_pipe_q[i-1];
    end
  end

  assign {oWR_EN, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1} = wr_pipe_q[D-1];

endmodule

// File: tb/tb_fht_ctrl.sv
// Self-checking bench for fht_ctrl with N_LOG2=3: a cycle-indexed model of the transform
// schedule checked every cycle, plus literal address/timing tables for the N=8 case.
module tb_fht_ctrl;

  localparam int NL    = 3;
  localparam int N     = 1 << NL;
  localparam int HALF  = N / 2;
  localparam int D     = 3;
  localparam int P     = HALF + D;
  localparam int TDONE = NL * P + 1;

  logic       iCLK, iRESET, iSTART;
  logic       oBUSY, oDONE, oRD_EN, oRD_BANK, oWR_EN, oWR_BANK;
  logic [1:0] oSTAGE, oTW_ADDR;
  logic [2:0] oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oWR_ADDR_0, oWR_ADDR_1;

  fht_ctrl #(.N_LOG2(NL), .RD_LAT(1), .BUT_LAT(2)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
    .oBUSY(oBUSY), .oDONE(oDONE), .oSTAGE(oSTAGE),
    .oRD_EN(oRD_EN), .oRD_BANK(oRD_BANK),
    .oRD_ADDR_0(oRD_ADDR_0), .oRD_ADDR_1(oRD_ADDR_1), .oRD_ADDR_2(oRD_ADDR_2),
    .oTW_ADDR(oTW_ADDR),
    .oWR_EN(oWR_EN), .oWR_BANK(oWR_BANK),
    .oWR_ADDR_0(oWR_ADDR_0), .oWR_ADDR_1(oWR_ADDR_1)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Hand-computed N=8 read schedule: stage 0, 1, 2, four butterflies each.
  int lit_a0 [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int lit_a1 [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int lit_a2 [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 7, 6, 5};
  int lit_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  // Model: t = cycle number within the current transform (0 = idle).
  int t = 0;
  always @(posedge iCLK) begin
    if (!iRESET)         t <= 0;
    else if (t == 0)     t <= iSTART ? 1 : 0;
    else if (t == TDONE) t <= 0;
    else                 t <= t + 1;
  end

  task automatic bfly(input int s, input int j, output int a0, output int a1,
                      output int a2, output int tw);
    int h, k, base;
    h    = 1 << s;
    k    = j % h;
    base = (j / h) * 2 * h;
    a0   = base + k;
    a1   = base + h + k;
    a2   = base + h + ((h - k) % h);
    tw   = k * (1 << (NL - 1 - s));
  endtask

  int e_rd, e_wr, e_busy, e_done, e_s, e_j, tr, a0, a1, a2, tw, li;

  always @(negedge iCLK) begin
    if (!iRESET) begin
      chk("rst_busy", oBUSY, 0);       chk("rst_done", oDONE, 0);
      chk("rst_stage", oSTAGE, 0);     chk("rst_rd_en", oRD_EN, 0);
      chk("rst_rd_bank", oRD_BANK, 0); chk("rst_rd_a0", oRD_ADDR_0, 0);
      chk("rst_rd_a1", oRD_ADDR_1, 0); chk("rst_rd_a2", oRD_ADDR_2, 0);
      chk("rst_tw", oTW_ADDR, 0);      chk("rst_wr_en", oWR_EN, 0);
      chk("rst_wr_bank", oWR_BANK, 0); chk("rst_wr_a0", oWR_ADDR_0, 0);
      chk("rst_wr_a1", oWR_ADDR_1, 0);
    end else begin
      e_busy = (t >= 1 && t < TDONE) ? 1 : 0;
      e_done = (t == TDONE) ? 1 : 0;
      e_rd   = 0;
      chk("busy", oBUSY, e_busy);
      chk("done", oDONE, e_done);
      if (e_busy == 1) begin
        e_s = (t - 1) / P;
        e_j = (t - 1) % P;
        chk("stage", oSTAGE, e_s);
        if (e_j < HALF) begin
          e_rd = 1;
          bfly(e_s, e_j, a0, a1, a2, tw);
          chk("rd_bank", oRD_BANK, e_s % 2);
          chk("rd_a0", oRD_ADDR_0, a0);
          chk("rd_a1", oRD_ADDR_1, a1);
          chk("rd_a2", oRD_ADDR_2, a2);
          chk("tw", oTW_ADDR, tw);
        end
      end
      chk("rd_en", oRD_EN, e_rd);
      tr   = t - D;
      e_wr = 0;
      if (tr >= 1 && tr < TDONE && ((tr - 1) % P) < HALF) begin
        e_wr = 1;
        bfly((tr - 1) / P, (tr - 1) % P, a0, a1, a2, tw);
        chk("wr_bank", oWR_BANK, 1 - (((tr - 1) / P) % 2));
        chk("wr_a0", oWR_ADDR_0, a0);
        chk("wr_a1", oWR_ADDR_1, a1);
      end
      chk("wr_en", oWR_EN, e_wr);

      // Literal N=8 expectations, independent of the model arithmetic.
      li = -1;
      if (t >= 1 && t <= 4)   li = t - 1;
      if (t >= 8 && t <= 11)  li = t - 4;
      if (t >= 15 && t <= 18) li = t - 7;
      if (t >= 1) begin
        chk("lit_rd_en", oRD_EN, (li >= 0) ? 1 : 0);
        chk("lit_busy", oBUSY, (t <= 21) ? 1 : 0);
        chk("lit_done", oDONE, (t == 22) ? 1 : 0);
        chk("lit_wr_en", oWR_EN, ((t >= 4 && t <= 7) || (t >= 11 && t <= 14)
                                  || (t >= 18 && t <= 21)) ? 1 : 0);
      end
      if (li >= 0) begin
        chk("lit_rd_a0", oRD_ADDR_0, lit_a0[li]);
        chk("lit_rd_a1", oRD_ADDR_1, lit_a1[li]);
        chk("lit_rd_a2", oRD_ADDR_2, lit_a2[li]);
        chk("lit_tw", oTW_ADDR, lit_tw[li]);
        if (t >= 15) chk("lit_rd_bank_s2", oRD_BANK, 0);
      end
      if (t >= 4 && t <= 7) begin
        chk("lit_wr_a0_s0", oWR_ADDR_0, 2 * (t - 4));
        chk("lit_wr_a1_s0", oWR_ADDR_1, 2 * (t - 4) + 1);
        chk("lit_wr_bank_s0", oWR_BANK, 1);
      end
      if (t >= 18 && t <= 21) chk("lit_wr_bank_s2", oWR_BANK, 1);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iCLK);
      #2;
    end
  endtask

  task automatic pulse_start();
    iSTART = 1'b1;
    tick(1);
    iSTART = 1'b0;
  endtask

  initial begin
    iRESET = 1'b1;
    iSTART = 1'b0;
    #1 iRESET = 1'b0;
    tick(2);
    iRESET = 1'b1;
    tick(1);

    // Single transform from a one-cycle start pulse.
    pulse_start();
    tick(30);

    // Start held high: back-to-back transforms; later pulses mid-run ignored.
    iSTART = 1'b1;
    tick(30);
    iSTART = 1'b0;
    tick(3);
    pulse_start();
    tick(4);
    pulse_start();
    tick(25);

    // Reset in stage 1 (cycle 9), then a fresh transform.
    pulse_start();
    tick(8);
    iRESET = 1'b0;
    tick(3);
    iRESET = 1'b1;
    tick(2);
    pulse_start();
    tick(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
